// File: rtl/burst_ram_if.sv
// Write port and burst-read stream of the SPI buffer RAM.
// The master side (SPI logic) drives requests; the slave side (RAM) drives the stream.
interface burst_ram_if #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 8
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_start;
    logic [ADDR_W-1:0] rd_base;
    logic [ADDR_W:0]   rd_len;
    logic              rd_abort;
    logic              rd_ready;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;
    logic              busy;
    logic              done;

    modport master (
        output wr_en, wr_addr, wr_data, rd_start, rd_base, rd_len, rd_abort, rd_ready,
        input  rd_valid, rd_data, rd_last, busy, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_start, rd_base, rd_len, rd_abort, rd_ready,
        output rd_valid, rd_data, rd_last, busy, done
    );
endinterface

// File: rtl/burst_ram.sv
// Random-write buffer RAM with a burst read engine streaming over valid/ready.
// Optional clear-on-read zeroes each location as the engine fetches it.
module burst_ram #(
    parameter int DATA_W      = 4,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 145,
    parameter int CLR_ON_READ = 0
) (
    input  logic       clock,
    input  logic       rst_n,
    burst_ram_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   REM_ONE  = (ADDR_W+1)'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];

    state_t            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W:0]   rem_q;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              last_q;
    logic              busy_q;
    logic              done_q;

    logic [ADDR_W-1:0] ptr_d;
    logic [ADDR_W-1:0] base_d;
    logic              issue_d;
    logic              clr_d;
    logic              wr_ok_d;

    // Next-pointer, folded base address and the issue / memory-write qualifiers
    always_comb begin
        ptr_d   = (ptr_q == PTR_LAST) ? {ADDR_W{1'b0}} : ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        base_d  = ADDR_W'({1'b0, bus.rd_base} % DEPTH_L);
        issue_d = rst_n && !bus.rd_abort && (state_q == RUN) && (rem_q != '0)
                  && (!valid_q || bus.rd_ready);
        clr_d   = (CLR_ON_READ != 0) && issue_d;
        wr_ok_d = rst_n && bus.wr_en && ({1'b0, bus.wr_addr} < DEPTH_L);
    end

    // Memory array: the clear is scheduled first so a same-edge write wins
    always_ff @(posedge clock) begin
        if (clr_d) begin
            mem_q[ptr_q] <= '0;
        end
        if (wr_ok_d) begin
            mem_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Burst engine FSM with registered stream and status outputs
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (bus.rd_abort && (state_q != IDLE)) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    busy_q <= bus.rd_start;
                    done_q <= bus.rd_start && (bus.rd_len == '0);
                    if (bus.rd_start) begin
                        if (bus.rd_len != '0) begin
                            state_q <= RUN;
                            ptr_q   <= base_d;
                            rem_q   <= bus.rd_len;
                        end else begin
                            state_q <= FIN;
                        end
                    end
                end
                RUN: begin
                    if (issue_d) begin
                        data_q  <= mem_q[ptr_q];
                        valid_q <= 1'b1;
                        last_q  <= (rem_q == REM_ONE);
                        ptr_q   <= ptr_d;
                        rem_q   <= rem_q - REM_ONE;
                    end else if (valid_q && bus.rd_ready) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        if (last_q) begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                        end
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rd_valid = valid_q;
    assign bus.rd_data  = data_q;
    assign bus.rd_last  = last_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule
